// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: MDU op encodings and FSM state constants shared with the decode stage.
package mult_div_unit_pkg;
  typedef enum logic [4:0] {
    MDU_err, MDU_mult, MDU_multu, MDU_div, MDU_divu,
    MDU_madd, MDU_maddu, MDU_msub, MDU_msubu,
    MDU_mthi, MDU_mtlo, MDU_mfhi, MDU_mflo
  } mdu_op_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdu_state_e;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit; result lands in a shadow and commits when the counter expires.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulate ops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  mdu_op,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] mdu_out
);
  localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);
  mdu_state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0] hi, lo, hi_nx, lo_nx, rt_safe;
  logic [63:0] shadow, shadow_nx, prod, div_res;
  logic signed [63:0] prod_s;
  logic signed [31:0] q_s, r_s;
  logic is_sgn, is_mul, is_div, is_acc, div_ovf, accept;
  assign is_sgn = mdu_op == MDU_mult || mdu_op == MDU_madd || mdu_op == MDU_msub;
  assign is_div = mdu_op == MDU_div || mdu_op == MDU_divu;
  assign prod_s = 64'($signed(rs_val)) * 64'($signed(rt_val));
  assign prod = is_sgn ? prod_s : {32'd0, rs_val} * {32'd0, rt_val};
`ifdef MDU_MADD_EN
  logic [63:0] acc_res;
  assign is_acc = mdu_op inside {MDU_madd, MDU_maddu, MDU_msub, MDU_msubu};
  assign acc_res = (mdu_op == MDU_msub || mdu_op == MDU_msubu) ? {hi, lo} - prod : {hi, lo} + prod;
`else
  assign is_acc = 1'b0;
`endif
  assign is_mul = mdu_op == MDU_mult || mdu_op == MDU_multu || is_acc;
  // Steer the divisor away from zero and the signed-overflow pair so the divider never sees them.
  assign div_ovf = rs_val == 32'h8000_0000 && rt_val == 32'hffff_ffff;
  assign rt_safe = (div_ovf || rt_val == 32'd0) ? 32'd1 : rt_val;
  assign q_s = $signed(rs_val) / $signed(rt_safe);
  assign r_s = $signed(rs_val) % $signed(rt_safe);
  assign div_res = rt_val == 32'd0 ? {hi, lo} :
                   mdu_op == MDU_divu ? {rs_val % rt_safe, rs_val / rt_safe} :
                   div_ovf ? {32'd0, 32'h8000_0000} : {r_s, q_s};
  assign accept = start && !cancel && state == IDLE;
  assign busy = state == RUN;
  assign md_stall = busy || (accept && (is_mul || is_div));
  assign mdu_out = mdu_op == MDU_mfhi ? hi : mdu_op == MDU_mflo ? lo : 32'd0;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    shadow_nx = shadow;
    hi_nx = hi;
    lo_nx = lo;
    if (state == IDLE) begin
      if (accept && (is_mul || is_div)) begin
        state_nx = RUN;
        cnt_nx = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
`ifdef MDU_MADD_EN
        shadow_nx = is_div ? div_res : is_acc ? acc_res : prod;
`else
        shadow_nx = is_div ? div_res : prod;
`endif
      end else if (accept && mdu_op == MDU_mthi) hi_nx = rs_val;
      else if (accept && mdu_op == MDU_mtlo) lo_nx = rs_val;
    end else begin
      cnt_nx = cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state_nx = IDLE;
        {hi_nx, lo_nx} = shadow;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      shadow <= shadow_nx;
      hi <= hi_nx;
      lo <= lo_nx;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table plus corner sequences for mult_div_unit, scoreboarded via HI/LO reads.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;
  logic clk = 0, reset = 0, start = 0, cancel = 0;
  logic [4:0] mdu_op = MDU_err;
  logic [31:0] rs_val = 0, rt_val = 0, mdu_out;
  logic busy, md_stall;
  int passed = 0, total = 0;
  logic [63:0] sb[$];
  typedef struct {
    logic [4:0] op;
    logic [31:0] rs, rt, pre_hi, pre_lo, exp_hi, exp_lo;
    int cyc;
  } vec_t;
  vec_t v[10];
  mult_div_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .mdu_op(mdu_op), .start(start), .cancel(cancel),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .md_stall(md_stall), .mdu_out(mdu_out)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_op = op;
    rs_val = a;
    rt_val = b;
    start = 1;
  endtask
  task automatic idle_bus;
    start = 0;
    cancel = 0;
    mdu_op = MDU_err;
  endtask
  task automatic write_hl(input logic [31:0] h, input logic [31:0] l);
    issue(MDU_mthi, h, 0);
    tick;
    issue(MDU_mtlo, l, 0);
    tick;
    idle_bus;
  endtask
  task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
    mdu_op = MDU_mfhi;
    #1 h = mdu_out;
    mdu_op = MDU_mflo;
    #1 l = mdu_out;
    mdu_op = MDU_err;
  endtask
  task automatic wait_idle(inout int n);
    while (busy && n < 40) begin
      n++;
      tick;
    end
  endtask
  initial begin
    logic [31:0] h, l;
    logic [63:0] e;
    int n;
`ifdef MDU_MADD_EN
    v[6] = '{MDU_madd,  32'hffffffff, 32'hffffffff, 32'h1, 32'h0, 32'h1, 32'h1, 5};
    v[7] = '{MDU_msubu, 32'h2, 32'h3, 32'h0, 32'h5, 32'hffffffff, 32'hffffffff, 5};
`else
    v[6] = '{MDU_madd,  32'hffffffff, 32'hffffffff, 32'h1, 32'h0, 32'h1, 32'h0, 0};
    v[7] = '{MDU_msubu, 32'h2, 32'h3, 32'h0, 32'h5, 32'h0, 32'h5, 0};
`endif
    v[0] = '{MDU_mult,  32'hfffffffe, 32'h3, 32'h0, 32'h0, 32'hffffffff, 32'hfffffffa, 5};
    v[1] = '{MDU_multu, 32'hfffffffe, 32'h3, 32'h0, 32'h0, 32'h00000002, 32'hfffffffa, 5};
    v[2] = '{MDU_div,   32'hfffffff9, 32'h2, 32'h0, 32'h0, 32'hffffffff, 32'hfffffffd, 10};
    v[3] = '{MDU_divu,  32'h7b, 32'h0, 32'hffffffff, 32'hfffffffd, 32'hffffffff, 32'hfffffffd, 10};
    v[4] = '{MDU_div,   32'h80000000, 32'hffffffff, 32'h5, 32'h6, 32'h0, 32'h80000000, 10};
    v[5] = '{MDU_divu,  32'hffffffff, 32'h10, 32'h0, 32'h0, 32'h0000000f, 32'h0fffffff, 10};
    v[8] = '{MDU_mult,  32'h7, 32'hfffffffd, 32'h0, 32'h0, 32'hffffffff, 32'hffffffeb, 5};
    v[9] = '{MDU_div,   32'h7, 32'hfffffffe, 32'h0, 32'h0, 32'h00000001, 32'hfffffffd, 10};
    #12 reset = 1;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_stall", md_stall, 0);
    read_hl(h, l);
    chk("rst_hi", h, 0);
    chk("rst_lo", l, 0);
    chk("out_zero_err", mdu_out, 0);
    foreach (v[i]) begin
      write_hl(v[i].pre_hi, v[i].pre_lo);
      sb.push_back({v[i].exp_hi, v[i].exp_lo});
      issue(v[i].op, v[i].rs, v[i].rt);
      #1 chk($sformatf("v%0d_stall", i), md_stall, v[i].cyc != 0);
      tick;
      idle_bus;
      n = 0;
      wait_idle(n);
      chk($sformatf("v%0d_busy_cycles", i), n, v[i].cyc);
      read_hl(h, l);
      e = sb.pop_front();
      chk($sformatf("v%0d_hi", i), h, e[63:32]);
      chk($sformatf("v%0d_lo", i), l, e[31:0]);
    end
    // mult with mtlo held during RUN (and a cancel that must not abort)
    write_hl(0, 0);
    sb.push_back(64'd42);
    issue(MDU_mult, 6, 7);
    tick;
    mdu_op = MDU_mtlo;
    rs_val = 32'h55;
    cancel = 1;
    #1 chk("run_stall", md_stall, 1);
    tick;
    cancel = 0;
    n = 1;
    while (busy && n < 40) begin
      chk("run_stall", md_stall, 1);
      n++;
      tick;
    end
    chk("run_busy_cycles", n, 5);
    chk("idle_mtlo_stall", md_stall, 0);
    e = sb.pop_front();
    mdu_op = MDU_mflo;
    #1 chk("commit_lo", mdu_out, e[31:0]);
    mdu_op = MDU_mfhi;
    #1 chk("commit_hi", mdu_out, e[63:32]);
    mdu_op = MDU_mtlo;
    tick;
    idle_bus;
    read_hl(h, l);
    chk("late_mtlo_lo", l, 32'h55);
    chk("late_mtlo_hi", h, 0);
    // reset two cycles into a div
    write_hl(32'haaaa, 32'hbbbb);
    issue(MDU_div, 100, 7);
    tick;
    idle_bus;
    tick;
    #2 reset = 0;
    #1 chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall", md_stall, 0);
    read_hl(h, l);
    chk("mid_rst_hi", h, 0);
    chk("mid_rst_lo", l, 0);
    tick;
    reset = 1;
    issue(MDU_mthi, 32'h1234, 0);
    cancel = 1;
    tick;
    issue(MDU_div, 100, 7);
    cancel = 1;
    #1 chk("cancel_stall", md_stall, 0);
    tick;
    idle_bus;
    chk("cancel_busy", busy, 0);
    read_hl(h, l);
    chk("cancel_hi", h, 0);
    chk("cancel_lo", l, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
